iter_divider: RTL and testbench

Multicycle unsigned integer divider. It computes quotient and remainder with one restoring shift-subtract step per clock, which makes it the subtractive inverse of the datapath adder. It sits beside the ALU in the multicycle datapath. The controller pulses start, then stalls on busy until done.

---
 rtl/iter_divider.sv | 104 ++++++++++
 tb/tb_iter_divider.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Multicycle unsigned divider: one restoring shift-subtract step per clock.
// Divide by zero skips the iteration and reports all-ones quotient with the dividend as remainder.
module iter_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;

  // The partial remainder stays below the divisor, so its top bit is never needed;
  // the difference is only used when it is non-negative, so WIDTH bits suffice.
  assign w_shift    = {r_rem, r_q[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_d});
  assign w_diff     = w_shift[WIDTH-1:0] - r_d;
  assign w_rem_next = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign w_q_next   = {r_q[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem   <= '0;
            r_q     <= dividend;
            r_d     <= divisor;
            r_count <= CW'(WIDTH - 1);
            r_dbz   <= 1'b0;
            r_state <= (divisor == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          r_rem   <= w_rem_next;
          r_q     <= w_q_next;
          r_count <= r_count - CW'(1);
          if (r_count == '0) begin
            r_state     <= S_DONE;
            r_quotient  <= w_q_next;
            r_remainder <= w_rem_next;
            r_done      <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          // Zero divisor: results are published on the way out of DONE.
          if (r_d == '0) begin
            r_quotient  <= '1;
            r_remainder <= r_q;
            r_dbz       <= 1'b1;
            r_done      <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider at WIDTH=8 and WIDTH=16 with directed vectors.
module tb_iter_divider;

  logic        clk;
  logic        rst_n;
  logic        start8, start16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy8, done8, dz8;
  logic [7:0]  quo8, rem8;
  logic        busy16, done16, dz16;
  logic [15:0] quo16, rem16;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          acc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  int   cyc;
  int   n_checks;
  int   n_pass;

  iter_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst_n), .start(start8), .dividend(a8), .divisor(b8),
    .busy(busy8), .done(done8), .quotient(quo8), .remainder(rem8), .div_by_zero(dz8)
  );

  iter_divider #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(rst_n), .start(start16), .dividend(a16), .divisor(b16),
    .busy(busy16), .done(done16), .quotient(quo16), .remainder(rem16), .div_by_zero(dz16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitors: pop and compare whenever a DUT presents done.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) chk("unexpected_done8", 1, 0);
      else begin
        e8 = q8.pop_front();
        chk("quo8", {24'd0, quo8}, {16'd0, e8.q});
        chk("rem8", {24'd0, rem8}, {16'd0, e8.r});
        chk("dz8", {31'd0, dz8}, {31'd0, e8.dz});
        chk("lat8", cyc - e8.acc, e8.dz ? 1 : 8);
        $display("w8  q=%0d r=%0d dz=%0d", quo8, rem8, dz8);
      end
    end
  end

  always @(negedge clk) begin
    if (done16) begin
      if (q16.size() == 0) chk("unexpected_done16", 1, 0);
      else begin
        e16 = q16.pop_front();
        chk("quo16", {16'd0, quo16}, {16'd0, e16.q});
        chk("rem16", {16'd0, rem16}, {16'd0, e16.r});
        chk("dz16", {31'd0, dz16}, {31'd0, e16.dz});
        chk("lat16", cyc - e16.acc, e16.dz ? 1 : 16);
        $display("w16 q=%0d r=%0d dz=%0d", quo16, rem16, dz16);
      end
    end
  end

  // Issue one start; when 'acc' is set the start must be accepted and the
  // hand-computed result is queued. 'now' skips the wait for the next negedge.
  task automatic issue(input bit sel, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er,
                       input bit acc, input bit now);
    exp_t e;
    if (!now) @(negedge clk);
    if (sel) begin start16 = 1'b1; a16 = a; b16 = b; end
    else     begin start8  = 1'b1; a8 = a[7:0]; b8 = b[7:0]; end
    @(posedge clk);
    #1;
    start8  = 1'b0;
    start16 = 1'b0;
    // Scramble operands after acceptance; the result must not change.
    a8  = 8'($urandom);
    b8  = 8'($urandom);
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    if (acc) begin
      chk(sel ? "accept16" : "accept8", {31'd0, sel ? busy16 : busy8}, 1);
      e.q = eq; e.r = er; e.dz = (b == 16'd0); e.acc = cyc;
      if (sel) q16.push_back(e); else q8.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q8.size() == 0 && q16.size() == 0) break;
      @(negedge clk);
      #1;
    end
    chk("drain_pending", q8.size() + q16.size(), 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy8}, 0);
    chk("rst_done", {31'd0, done8}, 0);
    chk("rst_quo", {24'd0, quo8}, 0);
    chk("rst_rem", {24'd0, rem8}, 0);
    chk("rst_dz", {31'd0, dz8}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic divide, then done must drop with results held.
    issue(0, 100, 7, 14, 2, 1, 0);
    drain();
    @(negedge clk);
    chk("done_pulse", {31'd0, done8}, 0);
    chk("hold_quo", {24'd0, quo8}, 14);
    chk("hold_rem", {24'd0, rem8}, 2);

    issue(0, 255, 1, 255, 0, 1, 0);   drain();
    issue(0, 5, 9, 0, 5, 1, 0);       drain();
    issue(0, 200, 200, 1, 0, 1, 0);   drain();
    // Divide by zero, then a start in the very cycle done is shown.
    issue(0, 42, 0, 255, 42, 1, 0);   drain();
    issue(0, 9, 3, 3, 0, 1, 1);       drain();
    issue(0, 0, 0, 255, 0, 1, 0);     drain();
    issue(0, 0, 255, 0, 0, 1, 0);     drain();
    issue(0, 255, 255, 1, 0, 1, 0);   drain();
    issue(0, 255, 16, 15, 15, 1, 0);  drain();
    issue(0, 128, 3, 42, 2, 1, 0);    drain();

    // Starts during RUN (edge +3) and DONE (edge +9) are ignored.
    issue(0, 100, 7, 14, 2, 1, 0);
    repeat (2) @(posedge clk);
    #1 start8 = 1'b1; a8 = 50; b8 = 5;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (5) @(posedge clk);
    #1 start8 = 1'b1; a8 = 50; b8 = 5;
    @(posedge clk);
    #1 start8 = 1'b0;
    issue(0, 50, 5, 10, 0, 1, 1);
    drain();

    // Reset mid-run aborts without a done.
    issue(0, 100, 7, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy8}, 0);
    chk("abort_done", {31'd0, done8}, 0);
    chk("abort_quo", {24'd0, quo8}, 0);
    chk("abort_rem", {24'd0, rem8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("idle_after_abort", {31'd0, busy8}, 0);

    // 16-bit instance.
    issue(1, 16'd65535, 16'd1, 16'd65535, 16'd0, 1, 0);   drain();
    issue(1, 16'd65535, 16'd255, 16'd257, 16'd0, 1, 0);   drain();
    issue(1, 16'd1000, 16'd0, 16'hFFFF, 16'd1000, 1, 0);  drain();
    issue(1, 16'd0, 16'd7, 16'd0, 16'd0, 1, 0);           drain();
    issue(1, 16'd50000, 16'd123, 16'd406, 16'd62, 1, 0);  drain();
    issue(1, 16'd65535, 16'd65535, 16'd1, 16'd0, 1, 0);   drain();
    issue(1, 16'd12345, 16'd65535, 16'd0, 16'd12345, 1, 0); drain();

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
